// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM states, next-PC source selects,
// default vectors and widths.
package fetch_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned ADDR_W = 20;

  localparam logic [31:0] RESET_VEC = 32'd32;
  localparam logic [31:0] ISR_VEC   = 32'd0;
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic {
    RUN,
    ISR
  } fetch_state_t;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BRANCH,
    SEL_RTI,
    SEL_HOLD,
    SEL_INTR
  } pc_sel_t;

endpackage

// File: rtl/fetch_pc_mux.sv
// Combinational next-PC arbitration. Priority order: branch, rti (ISR only), stall,
// interrupt entry (RUN only), sequential increment.
module fetch_pc_mux
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] ISR_ADDR = '0
) (
  input  fetch_state_t      state,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              rti,
  input  logic              intr_req,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] epc,
  output pc_sel_t           sel,
  output logic [ADDR_W-1:0] next_pc,
  output fetch_state_t      next_state,
  output logic              intr_ack
);

  always_comb begin
    sel        = SEL_SEQ;
    next_pc    = pc + ADDR_W'(1);  // wraps at 2**ADDR_W by width
    next_state = state;
    intr_ack   = 1'b0;
    if (branch_taken) begin
      sel     = SEL_BRANCH;
      next_pc = branch_addr;
    end else if (rti && state == ISR) begin
      sel        = SEL_RTI;
      next_pc    = epc;
      next_state = RUN;
    end else if (stall) begin
      sel     = SEL_HOLD;
      next_pc = pc;
    end else if (intr_req && state == RUN) begin
      sel        = SEL_INTR;
      next_pc    = ISR_ADDR;
      next_state = ISR;
      intr_ack   = 1'b1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC sequencer: drives the instruction memory address, registers the returned
// word into IF/ID and handles branch, interrupt entry/return and stall.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned     PC_W      = fetch_pkg::PC_W,
  parameter int unsigned     ADDR_W    = fetch_pkg::ADDR_W,
  parameter logic [PC_W-1:0] RESET_VEC = fetch_pkg::RESET_VEC,
  parameter logic [PC_W-1:0] ISR_VEC   = fetch_pkg::ISR_VEC,
  parameter logic [15:0]     NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] pc_out,
  input  logic [15:0]     mem_instr,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            rti,
  input  logic            intr_req,
  output logic            intr_ack,
  output logic            in_isr,
  output logic [15:0]     ifid_instr,
  output logic [PC_W-1:0] ifid_pc,
  output logic            ifid_valid
);

  fetch_state_t      state, next_state;
  pc_sel_t           sel;
  logic [ADDR_W-1:0] pc, epc, next_pc;
  logic              mux_ack;
  logic              unused_target_hi;

  // Only the implemented address bits are kept; the upper PC bits are tied to zero.
  assign pc_out           = {{(PC_W-ADDR_W){1'b0}}, pc};
  assign in_isr           = (state == ISR);
  assign intr_ack         = mux_ack & ~rst;
  assign unused_target_hi = ^branch_target[PC_W-1:ADDR_W];

  fetch_pc_mux #(
    .ADDR_W   (ADDR_W),
    .ISR_ADDR (ISR_VEC[ADDR_W-1:0])
  ) u_pc_mux (
    .state        (state),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_addr  (branch_target[ADDR_W-1:0]),
    .rti          (rti),
    .intr_req     (intr_req),
    .pc           (pc),
    .epc          (epc),
    .sel          (sel),
    .next_pc      (next_pc),
    .next_state   (next_state),
    .intr_ack     (mux_ack)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= next_state;
  end

  // Redirects insert a bubble but leave ifid_pc at its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_VEC[ADDR_W-1:0];
      epc        <= '0;
      ifid_instr <= NOP_INSTR;
      ifid_pc    <= '0;
      ifid_valid <= 1'b0;
    end else begin
      pc <= next_pc;
      case (sel)
        SEL_SEQ: begin
          ifid_instr <= mem_instr;
          ifid_pc    <= pc_out;
          ifid_valid <= 1'b1;
        end
        SEL_HOLD: ;
        SEL_INTR: begin
          epc        <= pc;
          ifid_instr <= NOP_INSTR;
          ifid_valid <= 1'b0;
        end
        default: begin
          ifid_instr <= NOP_INSTR;
          ifid_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: per-cycle vector table with hand-computed outputs,
// followed by a short sequential-run sequence.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_out;
  logic [15:0] mem_instr;
  logic        stall, branch_taken, rti, intr_req;
  logic [31:0] branch_target;
  logic        intr_ack, in_isr, ifid_valid;
  logic [15:0] ifid_instr;
  logic [31:0] ifid_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instruction memory model: word is a fixed function of its address.
  assign mem_instr = pc_out[15:0] ^ 16'hA5A5;

  fetch_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .pc_out        (pc_out),
    .mem_instr     (mem_instr),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .rti           (rti),
    .intr_req      (intr_req),
    .intr_ack      (intr_ack),
    .in_isr        (in_isr),
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc),
    .ifid_valid    (ifid_valid)
  );

  typedef struct {
    logic        rst, stall, br, rti, intr;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic [31:0] ipc;
    logic        chk_ipc, v, ack, isr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic s, input logic b, input logic t,
                              input logic i, input logic [31:0] tgt, input logic [31:0] pc,
                              input logic [31:0] ipc, input logic cp, input logic v,
                              input logic ack, input logic isr);
    vec_t x;
    x.rst = r; x.stall = s; x.br = b; x.rti = t; x.intr = i; x.tgt = tgt;
    x.pc = pc; x.ipc = ipc; x.chk_ipc = cp; x.v = v; x.ack = ack; x.isr = isr;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    logic [15:0] exp_instr;
    logic [31:0] base;

    //            rst st br rti in target         pc_out        ifid_pc       cp v  ack isr
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'd32,       32'd0,        1, 0, 0, 0)); // r0 reset state
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'd33,       32'd32,       1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,        32'd34,       32'd33,       1, 1, 0, 0)); // stall
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,        32'd34,       32'd33,       1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'd34,       32'd33,       1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'd35,       32'd34,       1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h0010_0040,32'd36,       32'd35,       1, 1, 0, 0)); // branch
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'h40,       32'd0,        0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0,        32'h41,       32'h40,       1, 1, 1, 0)); // intr
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0,        32'h0,        32'd0,        0, 0, 0, 1)); // masked
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'h1,        32'h0,        1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 32'h0,        32'h2,        32'h1,        1, 1, 0, 1)); // rti
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'h41,       32'd0,        0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0,        32'h42,       32'h41,       1, 1, 1, 0)); // intr again
    tbl.push_back(mk(0, 1, 1, 0, 1, 32'h100,      32'h0,        32'd0,        0, 0, 0, 1)); // br+stall+intr in ISR
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h0,        32'h100,      32'd0,        0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 1, 32'h0,        32'h100,      32'd0,        0, 0, 0, 1)); // rti beats stall
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h0,        32'h42,       32'd0,        0, 0, 0, 0)); // stall defers intr
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0,        32'h42,       32'd0,        0, 0, 1, 0)); // accepted now
    tbl.push_back(mk(0, 0, 1, 1, 0, 32'h200,      32'h0,        32'd0,        0, 0, 0, 1)); // br+rti: br wins
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'h200,      32'd0,        0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 32'h0,        32'h201,      32'h200,      1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 32'h0,        32'h42,       32'd0,        0, 0, 0, 0)); // rti in RUN ignored
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'hABCF_FFFF,32'h43,       32'h42,       1, 1, 0, 0)); // br+intr, truncate
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'hF_FFFF,   32'd0,        0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'hF_FFFF,   1, 1, 0, 0)); // wrap
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0,        32'h1,        32'h0,        1, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 32'h0,        32'h0,        32'd0,        0, 0, 0, 1)); // rst mid-ISR
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'd32,       32'd0,        1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 32'h0,        32'd33,       32'd32,       1, 1, 0, 0)); // ack gated by rst
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'd32,       32'd0,        1, 0, 0, 0));

    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; rti = 1'b0; intr_req = 1'b0;
    branch_target = '0;
    @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; stall = tbl[i].stall; branch_taken = tbl[i].br;
      rti = tbl[i].rti; intr_req = tbl[i].intr; branch_target = tbl[i].tgt;
      #1;
      exp_instr = tbl[i].v ? (tbl[i].ipc[15:0] ^ 16'hA5A5) : 16'h0000;
      check($sformatf("r%0d pc_out", i), pc_out, tbl[i].pc);
      check($sformatf("r%0d ifid_valid", i), 32'(ifid_valid), 32'(tbl[i].v));
      check($sformatf("r%0d ifid_instr", i), 32'(ifid_instr), 32'(exp_instr));
      check($sformatf("r%0d intr_ack", i), 32'(intr_ack), 32'(tbl[i].ack));
      check($sformatf("r%0d in_isr", i), 32'(in_isr), 32'(tbl[i].isr));
      if (tbl[i].chk_ipc) check($sformatf("r%0d ifid_pc", i), ifid_pc, tbl[i].ipc);
    end

    // Free run after the last reset: pc_out climbs from 33, ifid tracks one behind.
    base = 32'd33;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; rti = 1'b0; intr_req = 1'b0;
      #1;
      check($sformatf("run%0d pc_out", k), pc_out, base + 32'(k));
      check($sformatf("run%0d ifid_pc", k), ifid_pc, base + 32'(k) - 32'd1);
      check($sformatf("run%0d ifid_valid", k), 32'(ifid_valid), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
